bayer_streamer: RTL and testbench

Raw Bayer pixel source for the demosaic stage. On a `go` pulse it reads one raw frame from a synchronous frame buffer and replays it on the demosaic input protocol (`start`, `valid`, `data_out`, `end_col`, `end_pic`). Pixels are sent column-major within overlapping horizontal strips. The block sits between the frame buffer and `demosaic`, and is the transmit end of the interface that `demosaic` receives.

---
 rtl/bayer_streamer.sv | 205 ++++++++++++++++++++
 tb/tb_bayer_streamer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bayer_streamer.sv
// bayer_streamer: reads one raw Bayer frame from a synchronous frame buffer
// and replays it column-major within overlapping horizontal strips on the
// demosaic input protocol (start / valid / data_out / end_col / end_pic).
module bayer_streamer #(
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 12,
  parameter int STRIP_H    = 8,
  parameter int STRIP_STEP = 4,
  parameter int GAP        = 2,
  parameter int DW         = 8,
  parameter int AW         = $clog2(IMG_W * IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          start,
  output logic          valid,
  output logic [DW-1:0] data_out,
  output logic          end_col,
  output logic          end_pic,
  output logic          busy,
  output logic          done
);

  localparam int NS = (IMG_H - STRIP_H) / STRIP_STEP + 1;
  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(STRIP_H + 1);
  localparam int SW = $clog2(NS + 1);
  localparam int GW = $clog2(GAP + 1);

  localparam logic [AW-1:0] ROW_INC   = AW'(IMG_W);
  localparam logic [AW-1:0] STRIP_INC = AW'(IMG_W * STRIP_STEP);
  // With the minimum gap the read must go out in the very first WAIT cycle,
  // so it is launched on the transition into WAIT.
  localparam bit RD_FIRST = (GAP == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t state_q;

  logic [CW-1:0] c_q, c_d;
  logic [RW-1:0] r_q, r_d;
  logic [SW-1:0] s_q, s_d;
  logic [GW-1:0] gap_q;
  // strip_q: address of (c=0, r=0) of the current strip
  // col_q:   address of (c, r=0) of the current column
  // addr_q:  address of the current pixel
  logic [AW-1:0] strip_q, strip_d;
  logic [AW-1:0] col_q, col_d;
  logic [AW-1:0] addr_q, addr_d;

  logic          rd_en_q;
  logic [AW-1:0] rd_addr_q;
  logic          start_q, valid_q, end_col_q, end_pic_q, busy_q, done_q;
  logic [DW-1:0] data_q;

  logic last_row, last_col, last_strip;

  assign last_row   = (r_q == RW'(STRIP_H - 1));
  assign last_col   = (c_q == CW'(IMG_W - 1));
  assign last_strip = (s_q == SW'(NS - 1));

  // Next pixel position and address, advanced incrementally (no multiplier).
  always_comb begin
    c_d     = c_q;
    r_d     = r_q;
    s_d     = s_q;
    strip_d = strip_q;
    col_d   = col_q;
    addr_d  = addr_q;
    if (last_row) begin
      r_d = '0;
      if (last_col) begin
        c_d     = '0;
        s_d     = s_q + 1'b1;
        strip_d = strip_q + STRIP_INC;
        col_d   = strip_d;
        addr_d  = strip_d;
      end else begin
        c_d    = c_q + 1'b1;
        col_d  = col_q + 1'b1;
        addr_d = col_d;
      end
    end else begin
      r_d    = r_q + 1'b1;
      addr_d = addr_q + ROW_INC;
    end
  end

  // Frame sequencer: state, pixel counters and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      c_q       <= '0;
      r_q       <= '0;
      s_q       <= '0;
      gap_q     <= '0;
      strip_q   <= '0;
      col_q     <= '0;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      end_col_q <= 1'b0;
      end_pic_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      end_col_q <= 1'b0;
      end_pic_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (go) begin
            state_q <= S_START;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            c_q     <= '0;
            r_q     <= '0;
            s_q     <= '0;
            strip_q <= '0;
            col_q   <= '0;
            addr_q  <= '0;
          end
        end
        S_START: begin
          state_q <= S_WAIT;
          gap_q   <= GW'(1);
          if (RD_FIRST) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= addr_q;
          end
        end
        S_WAIT: begin
          if (gap_q == GW'(GAP)) begin
            // rd_data answers the read issued in the previous cycle
            state_q   <= S_EMIT;
            valid_q   <= 1'b1;
            data_q    <= rd_data;
            end_col_q <= last_col && last_row;
            end_pic_q <= last_col && last_row && last_strip;
          end else begin
            gap_q <= gap_q + 1'b1;
            if (gap_q == GW'(GAP - 2)) begin
              rd_en_q   <= 1'b1;
              rd_addr_q <= addr_q;
            end
          end
        end
        S_EMIT: begin
          if (end_pic_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_WAIT;
            gap_q   <= GW'(1);
            c_q     <= c_d;
            r_q     <= r_d;
            s_q     <= s_d;
            strip_q <= strip_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            if (RD_FIRST) begin
              rd_en_q   <= 1'b1;
              rd_addr_q <= addr_d;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign start    = start_q;
  assign valid    = valid_q;
  assign data_out = data_q;
  assign end_col  = end_col_q;
  assign end_pic  = end_pic_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_bayer_streamer.sv
// Bench for bayer_streamer: frame-buffer model, reference pixel order built
// from nested strip/column/row loops, cycle-by-cycle protocol checks.
module tb_bayer_streamer;

  localparam int IMG_W = 8, IMG_H = 12, STRIP_H = 8, STEP = 4, DW = 8, AW = 7;
  localparam int NS = (IMG_H - STRIP_H) / STEP + 1;
  localparam int N = IMG_W * STRIP_H * NS;
  localparam int MEMSZ = IMG_W * IMG_H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, go, go4, sel4;
  logic          rd_en, rd_en4;
  logic [AW-1:0] rd_addr, rd_addr4;
  logic [DW-1:0] rd_data, rd_data4, data_out, data_out4;
  logic start, valid, end_col, end_pic, busy, done;
  logic start4, valid4, end_col4, end_pic4, busy4, done4;

  bayer_streamer dut (
    .clk(clk), .rst(rst), .go(go), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .start(start), .valid(valid), .data_out(data_out),
    .end_col(end_col), .end_pic(end_pic), .busy(busy), .done(done)
  );

  bayer_streamer #(.GAP(4)) dut4 (
    .clk(clk), .rst(rst), .go(go4), .rd_en(rd_en4), .rd_addr(rd_addr4),
    .rd_data(rd_data4), .start(start4), .valid(valid4), .data_out(data_out4),
    .end_col(end_col4), .end_pic(end_pic4), .busy(busy4), .done(done4)
  );

  logic [DW-1:0] mem [MEMSZ];
  int            exp_addr [N];
  logic [DW-1:0] exp_data [N];
  logic [DW-1:0] got [N];
  int ncol;
  int total = 0, bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous frame buffers, one per instance
  always @(posedge clk) begin
    if (rd_en)  rd_data  <= mem[rd_addr];
    if (rd_en4) rd_data4 <= mem[rd_addr4];
  end

  logic          m_start, m_valid, m_end_col, m_end_pic, m_busy, m_done, m_rd_en;
  logic [AW-1:0] m_rd_addr;
  logic [DW-1:0] m_data;
  always_comb begin
    if (sel4) begin
      m_start = start4; m_valid = valid4; m_end_col = end_col4; m_end_pic = end_pic4;
      m_busy = busy4; m_done = done4; m_rd_en = rd_en4; m_rd_addr = rd_addr4; m_data = data_out4;
    end else begin
      m_start = start; m_valid = valid; m_end_col = end_col; m_end_pic = end_pic;
      m_busy = busy; m_done = done; m_rd_en = rd_en; m_rd_addr = rd_addr; m_data = data_out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".start"}, m_start, 0);
    chk({tag, ".valid"}, m_valid, 0);
    chk({tag, ".done"}, m_done, 0);
    chk({tag, ".busy"}, m_busy, 0);
    chk({tag, ".rd_en"}, m_rd_en, 0);
    chk({tag, ".rd_addr"}, m_rd_addr, 0);
    chk({tag, ".data"}, m_data, 0);
    chk({tag, ".ends"}, {m_end_col, m_end_pic}, 0);
  endtask

  // Fill the frame buffer and derive the expected pixel stream from the
  // strip/column/row ordering rules.
  task automatic build_model(input bit ramp);
    int k;
    for (int a = 0; a < MEMSZ; a++) mem[a] = ramp ? DW'(a) : DW'($urandom);
    k = 0;
    for (int s = 0; s < NS; s++)
      for (int c = 0; c < IMG_W; c++)
        for (int r = 0; r < STRIP_H; r++) begin
          exp_addr[k] = c + IMG_W * (s * STEP + r);
          exp_data[k] = mem[exp_addr[k]];
          k++;
        end
  endtask

  task automatic raise_go();
    if (sel4) go4 = 1'b1; else go = 1'b1;
  endtask

  task automatic drop_go();
    go = 1'b0; go4 = 1'b0;
  endtask

  task automatic launch();
    @(negedge clk); raise_go();
    @(negedge clk); drop_go();
  endtask

  // Called at the negedge of the start cycle T; checks every cycle through done.
  task automatic frame_body(input int per, input int go_px, input bit go_done,
                            input int kill_px, output int tstart);
    bit pulsed = 0;
    tstart = cyc;
    ncol = 0;
    chk("start@T", m_start, 1);
    chk("busy@T", m_busy, 1);
    chk("valid@T", m_valid, 0);
    for (int t = 1; t <= per * N + 1; t++) begin
      bit ev, er;
      int k, kr;
      @(negedge clk);
      if (pulsed) begin drop_go(); pulsed = 0; end
      ev = (t % per == 0) && (t / per <= N);
      k  = t / per - 1;
      er = ((t + 2) % per == 0) && ((t + 2) / per <= N);
      kr = (t + 2) / per - 1;
      chk($sformatf("valid t=%0d", t), m_valid, ev);
      chk($sformatf("rd_en t=%0d", t), m_rd_en, er);
      chk($sformatf("done t=%0d", t), m_done, t == per * N + 1);
      chk($sformatf("busy t=%0d", t), m_busy, t <= per * N);
      chk($sformatf("start t=%0d", t), m_start, 0);
      if (ev) begin
        got[k] = m_data;
        if (m_end_col) ncol++;
        chk($sformatf("data k=%0d", k), m_data, exp_data[k]);
        chk($sformatf("end_col k=%0d", k), m_end_col,
            (k % (IMG_W * STRIP_H)) == IMG_W * STRIP_H - 1);
        chk($sformatf("end_pic k=%0d", k), m_end_pic, k == N - 1);
      end else begin
        chk($sformatf("ends idle t=%0d", t), {m_end_col, m_end_pic}, 0);
      end
      if (er) chk($sformatf("rd_addr k=%0d", kr), m_rd_addr, exp_addr[kr]);
      if ((go_px >= 0 && t == per * (go_px + 1)) || (go_done && t == per * N + 1)) begin
        raise_go();
        pulsed = 1;
      end
      if (kill_px >= 0 && t == per * (kill_px + 1)) begin
        rst = 1'b1;
        #1 chk_zero("kill0");
        @(negedge clk); chk_zero("kill1");
        @(negedge clk); chk_zero("kill2");
        rst = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    int ta, tb2;
    rst = 1'b1; go = 1'b1; go4 = 1'b0; sel4 = 1'b0;
    build_model(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_zero($sformatf("reset%0d", i));
    end
    rst = 1'b0; go = 1'b0;
    @(negedge clk); chk("idle.start", m_start, 0);

    // ramp memory, go mid-frame and during DONE are ignored
    launch();
    frame_body(3, 10, 1, -1, ta);
    chk("px0", got[0], 8'h00);
    chk("px1", got[1], 8'h08);
    chk("px7", got[7], 8'h38);
    chk("px8", got[8], 8'h01);
    chk("px63", got[63], 8'h3F);
    chk("px64", got[64], 8'h20);
    chk("px127", got[127], 8'h5F);
    chk("end_col count", ncol, 2);
    @(negedge clk); drop_go();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("go_in_done ignored", m_start, 0);
    end

    // reset mid-frame at pixel 40
    launch();
    frame_body(3, -1, 0, 40, ta);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk_zero("post-kill");
    end

    // fresh frames with random pixel data
    for (int f = 0; f < 2; f++) begin
      build_model(0);
      launch();
      frame_body(3, -1, 0, -1, ta);
      @(negedge clk);
    end

    // GAP=4 instance
    sel4 = 1'b1;
    build_model(0);
    launch();
    frame_body(5, -1, 0, -1, ta);
    @(negedge clk);
    sel4 = 1'b0;

    // go held high: back-to-back frames
    build_model(0);
    @(negedge clk); go = 1'b1;
    @(negedge clk);
    frame_body(3, -1, 0, -1, ta);
    @(negedge clk); chk("hold gap start", m_start, 0);
    @(negedge clk);
    frame_body(3, -1, 0, -1, tb2);
    go = 1'b0;
    chk("hold spacing", tb2 - ta, 387);
    @(negedge clk);
    @(negedge clk); chk("hold release", m_start, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
